// File: rtl/ex1_bool_fn_pkg.sv
// Shared definitions for the ex1 Boolean function cell.
// Provides the default truth table, the minterm index type and the lookup helper
// used by the top-level combinational path.
package ex1_pkg;

  // Default function: Y = (A & ~B) | (C & D), bit i is Y for {A,B,C,D} == i.
  localparam logic [15:0] DEFAULT_TT = 16'h8F88;

  // Minterm index, {A,B,C,D} with A as the MSB.
  typedef logic [3:0] minterm_t;

  // Select one truth-table bit. An X/Z index yields X, so unknown inputs
  // are not masked on the way to Y.
  function automatic logic tt_lookup(input logic [15:0] tt, input minterm_t idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/ex1_bool_fn_if.sv
// Signal bundle for the ex1 Boolean function cell.
// Ports: A..D function inputs; Y combinational output; y_q, idx_q registered
// copies; rise_cnt saturating count of y_q rising edges (CNT_W wide).
interface ex1_bool_fn_if #(
  parameter int CNT_W = 8
);
  import ex1_pkg::*;

  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             Y;
  logic             y_q;
  minterm_t         idx_q;
  logic [CNT_W-1:0] rise_cnt;

  // Master drives the function inputs and observes the results.
  modport master (
    output A, B, C, D,
    input  Y, y_q, idx_q, rise_cnt
  );

  // Slave is the function cell itself.
  modport slave (
    input  A, B, C, D,
    output Y, y_q, idx_q, rise_cnt
  );

endinterface

// File: rtl/ex1_bool_fn_edge_counter.sv
// Rising-edge detector with a saturating event counter.
// Ports: clk, rst_n (sync, active low); y_next is the value the watched
// register takes on this edge; rise_cnt counts 0->1 steps and sticks at all-ones.
module ex1_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_next,
  output logic [CNT_W-1:0] rise_cnt
);

  // y_prev tracks the watched register, so comparing it with y_next sees the
  // transition on the same edge the register changes. The count therefore
  // lines up with the registered value instead of trailing it by a cycle.
  logic y_prev;
  logic rise;
  logic sat;

  assign rise = y_next & ~y_prev;
  assign sat  = &rise_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_prev   <= 1'b0;
      rise_cnt <= '0;
    end else begin
      y_prev <= y_next;
      if (rise && !sat) begin
        rise_cnt <= rise_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ex1_bool_fn.sv
// Four-input Boolean function cell: Y = TRUTH_TABLE[{A,B,C,D}] with zero latency.
// Ports: clk, rst_n (sync, active low); bus (slave) carries A..D in and Y, y_q,
// idx_q (one-cycle registered copies) and rise_cnt (saturating y_q rise count) out.
module ex1_bool_fn
  import ex1_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = DEFAULT_TT,
  parameter int          CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ex1_bool_fn_if.slave  bus
);

  minterm_t idx;

  assign idx = {bus.A, bus.B, bus.C, bus.D};

  // Purely combinational: valid without any clock or reset activity.
  assign bus.Y = tt_lookup(TRUTH_TABLE, idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.y_q   <= 1'b0;
      bus.idx_q <= '0;
    end else begin
      bus.y_q   <= bus.Y;
      bus.idx_q <= idx;
    end
  end

  // Fed with Y, the value y_q is about to take, so rise_cnt updates on the
  // same edge as y_q.
  ex1_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .y_next   (bus.Y),
    .rise_cnt (bus.rise_cnt)
  );

endmodule

// File: tb/tb_ex1_bool_fn.sv
// Directed bench for ex1_bool_fn: default table (CNT_W=8), a CNT_W=2 instance for
// saturation, and a TRUTH_TABLE=16'h0001 instance. All share clk, rst_n and inputs.
module tb_ex1_bool_fn;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  ex1_bool_fn_if #(.CNT_W(8)) if_a ();
  ex1_bool_fn_if #(.CNT_W(2)) if_b ();
  ex1_bool_fn_if #(.CNT_W(8)) if_c ();

  ex1_bool_fn #(.CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  ex1_bool_fn #(.CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  ex1_bool_fn #(.TRUTH_TABLE(16'h0001), .CNT_W(8)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c)
  );

  // Clock stays still until the combinational sweeps are done.
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] i);
    {if_a.A, if_a.B, if_a.C, if_a.D} = i;
    {if_b.A, if_b.B, if_b.C, if_b.D} = i;
    {if_c.A, if_c.B, if_c.C, if_c.D} = i;
  endtask

  // Advance one clock and land 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_y;

    // Combinational sweep with no clock and no reset.
    for (int i = 0; i < 16; i++) begin
      drive(4'(i));
      #5;
      exp_y = (i == 3 || i == 7 || i == 8 || i == 9 || i == 10 || i == 11 || i == 15);
      check($sformatf("sweep_def_Y[%0d]", i), {31'd0, if_a.Y}, {31'd0, exp_y});
      check($sformatf("sweep_tt1_Y[%0d]", i), {31'd0, if_c.Y}, {31'd0, (i == 0)});
    end

    // Reset held for two clocks with inputs at 4'hF.
    clk_en = 1'b1;
    rst_n  = 1'b0;
    drive(4'hF);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_y_q", {31'd0, if_a.y_q}, 32'd0);
      check("rst_idx_q", {28'd0, if_a.idx_q}, 32'd0);
      check("rst_cnt", {24'd0, if_a.rise_cnt}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_y_q", {31'd0, if_a.y_q}, 32'd1);
    check("rel_idx_q", {28'd0, if_a.idx_q}, 32'hF);
    check("rel_cnt", {24'd0, if_a.rise_cnt}, 32'd1);
    check("rel_cnt_w2", {30'd0, if_b.rise_cnt}, 32'd1);
    check("rel_tt1_y_q", {31'd0, if_c.y_q}, 32'd0);
    check("rel_tt1_cnt", {24'd0, if_c.rise_cnt}, 32'd0);

    // Latency: index 8 then 4.
    drive(4'h8);
    tick();
    check("lat8_y_q", {31'd0, if_a.y_q}, 32'd1);
    check("lat8_idx_q", {28'd0, if_a.idx_q}, 32'h8);
    drive(4'h4);
    #1;
    check("lat4_Y_now", {31'd0, if_a.Y}, 32'd0);
    check("lat4_y_q_before", {31'd0, if_a.y_q}, 32'd1);
    tick();
    check("lat4_y_q", {31'd0, if_a.y_q}, 32'd0);
    check("lat4_idx_q", {28'd0, if_a.idx_q}, 32'h4);
    check("lat_cnt", {24'd0, if_a.rise_cnt}, 32'd1);

    // Edge count: 0,3,0,3,... for 10 cycles from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive((k % 2 == 1) ? 4'h3 : 4'h0);
      tick();
    end
    check("edge_cnt", {24'd0, if_a.rise_cnt}, 32'd5);
    check("edge_cnt_w2_sat", {30'd0, if_b.rise_cnt}, 32'd3);
    drive(4'h3);
    for (int k = 0; k < 4; k++) tick();
    check("hold_y_q", {31'd0, if_a.y_q}, 32'd1);
    check("hold_cnt", {24'd0, if_a.rise_cnt}, 32'd5);

    // Saturation on the CNT_W=2 instance: 8 rises.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("sat_rst_cnt_w2", {30'd0, if_b.rise_cnt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(4'h3);
      tick();
      if (k == 2) check("sat_cnt_w2_at3", {30'd0, if_b.rise_cnt}, 32'd3);
      drive(4'h0);
      tick();
    end
    check("sat_cnt_w2", {30'd0, if_b.rise_cnt}, 32'd3);
    check("sat_cnt_w8", {24'd0, if_a.rise_cnt}, 32'd8);
    rst_n = 1'b0;
    tick();
    check("sat_clr_cnt_w2", {30'd0, if_b.rise_cnt}, 32'd0);
    check("sat_clr_cnt_w8", {24'd0, if_a.rise_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex1_bool_fn.md
Name: ex1_bool_fn

Overview:
- Four-input Boolean function block; output Y is a fixed 4-variable function of inputs A, B, C, D.
- Y is purely combinational and independent of clock and reset.
- A registered copy of the output, the registered minterm index and a saturating count of Y rising edges are provided for downstream synchronous logic.
- Used as a standalone logic cell and as the reference gate for truth-table exhaustive checks.

Parameters:
- TRUTH_TABLE, 16'h8F88, bit i is Y for {A,B,C,D}==i. The default implements Y = (A & ~B) | (C & D).
- CNT_W, 8, width of the rising-edge counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- A  input  1  function input, MSB of index.
- B  input  1  function input.
- C  input  1  function input.
- D  input  1  function input, LSB of index.
- Y  output  1  combinational function output.
- y_q  output  1  Y registered on clk.
- idx_q  output  4  registered {A,B,C,D}.
- rise_cnt  output  CNT_W  number of 0->1 transitions of y_q.

Behaviour:
- Y = TRUTH_TABLE[{A,B,C,D}], zero latency, purely combinational.
  - Y must be valid with no clock toggling and reset never asserted.
  - Y settles within one propagation delay of any input change.
- Reset (rst_n==0 at a clk rising edge) sets y_q=0, idx_q=4'h0, rise_cnt=0.
  - Reset takes priority over all updates on the same edge.
- Normal edge: y_q <= Y, idx_q <= {A,B,C,D}, one-cycle latency.
- Rising-edge counting:
  - An internal y_prev register (reset 0) holds the previous y_q.
  - When y_q==1 and y_prev==0, rise_cnt increments by 1.
  - rise_cnt saturates at all-ones and never wraps.
- First cycle after reset release:
  - y_prev=0, so a y_q of 1 on that cycle counts as a rise.
- X/Z on any input propagates to Y. No input sanitising.
- No handshake and no state machine. Inputs are sampled every cycle.

Decomposition:
- Shared package ex1_pkg holds:
  - DEFAULT_TT = 16'h8F88;
  - typedef logic [3:0] minterm_t;
  - a function tt_lookup(tt, idx) returning one bit.
- Natural sub-module: ex1_edge_counter (rising-edge detect plus saturating counter, parameterised CNT_W).
- The top module instantiates ex1_edge_counter; the combinational lookup and registers live in the top.

Test Plan:
1. Exhaustive sweep of {A,B,C,D} from 0 to 15, 5 time units each, no clock, Y checked after settle.
   - Y==1 only at indices 3, 7, 8, 9, 10, 11, 15.
   - Y==0 at all other indices.
2. Reset: hold rst_n=0 for 2 clks with inputs 4'hF, then release.
   - y_q=0, idx_q=0, rise_cnt=0 during reset.
   - One clk after release: y_q=1, idx_q=4'hF, rise_cnt=1.
3. Latency check: drive index 8 then 4 on successive clks.
   - y_q follows 1 then 0, each one cycle late.
   - idx_q follows 8 then 4.
4. Edge count: alternate index 3 (Y=1) and 0 (Y=0) for 10 clk cycles.
   - rise_cnt == 5.
   - Holding index 3 steady adds no further counts.
5. Saturation with CNT_W=2: toggle Y for 8 rises.
   - rise_cnt stays at 3.
   - Assert rst_n=0 for one edge -> rise_cnt==0.
6. Override TRUTH_TABLE=16'h0001.
   - Y==1 only at index 0; Y==0 at indices 1 through 15.
